fetch_decode: RTL and testbench

Front-end stage directly upstream of the execute stage. Fetches 32-bit instruction words from a 1-cycle-latency instruction BRAM and splits them into fields. Reads the integer and float register files, with same-cycle writeback bypass, and presents one decoded instruction per cycle to execute. Obeys execute's stop (hold) and pcenable/next_pc (redirect) signals and accepts its register writebacks.

---
 rtl/fetch_decode_pkg.sv | 69 ++++++
 rtl/fetch_decode_if.sv | 41 ++++
 rtl/fetch_decode_regfile_dual.sv | 50 +++++
 rtl/fetch_decode.sv | 138 +++++++++++++
 tb/tb_fetch_decode.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared instruction-set package: opcode constants, field positions,
// front-end state encoding and the operand-file selection functions.
package inst_set;

    // Integer / memory / control opcodes
    localparam logic [5:0] INST_ADD    = 6'd0;
    localparam logic [5:0] INST_SUB    = 6'd1;
    localparam logic [5:0] INST_AND    = 6'd2;
    localparam logic [5:0] INST_OR     = 6'd3;
    localparam logic [5:0] INST_SLT    = 6'd4;
    localparam logic [5:0] INST_ADDI   = 6'd5;
    localparam logic [5:0] INST_LW     = 6'd6;
    localparam logic [5:0] INST_SW     = 6'd7;
    localparam logic [5:0] INST_BEQ    = 6'd8;
    localparam logic [5:0] INST_BLT    = 6'd9;
    localparam logic [5:0] INST_J      = 6'd10;
    localparam logic [5:0] INST_JAL    = 6'd11;
    localparam logic [5:0] INST_JR     = 6'd12;

    // Float group; FADD..ITOF must stay contiguous, fmode_rs relies on it
    localparam logic [5:0] INST_FADD   = 6'd16;
    localparam logic [5:0] INST_FSUB   = 6'd17;
    localparam logic [5:0] INST_FMUL   = 6'd18;
    localparam logic [5:0] INST_FDIV   = 6'd19;
    localparam logic [5:0] INST_FSQRT  = 6'd20;
    localparam logic [5:0] INST_FTOI   = 6'd21;
    localparam logic [5:0] INST_ITOF   = 6'd22;
    localparam logic [5:0] INST_SLTF   = 6'd23;
    localparam logic [5:0] INST_BEQF   = 6'd24;
    localparam logic [5:0] INST_BLTF   = 6'd25;
    localparam logic [5:0] INST_MOVF2I = 6'd26;
    localparam logic [5:0] INST_MOVI2F = 6'd27;
    localparam logic [5:0] INST_LWF    = 6'd28;
    localparam logic [5:0] INST_SWF    = 6'd29;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS_MSB  = 20;
    localparam int RS_LSB  = 16;
    localparam int RT_MSB  = 15;
    localparam int RT_LSB  = 11;
    localparam int OFF_MSB = 15;
    localparam int OFF_LSB = 0;

    // Front-end sequencing states
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fd_state_t;

    // rs comes from the float file for the float group, float compares,
    // float branches and float-to-int moves
    function automatic logic fmode_rs(input logic [5:0] op);
        return ((op >= INST_FADD) && (op <= INST_ITOF)) ||
               (op == INST_SLTF) || (op == INST_BEQF) ||
               (op == INST_BLTF) || (op == INST_MOVF2I);
    endfunction

    // rt comes from the float file only for two-operand float instructions
    function automatic logic fmode_rt(input logic [5:0] op);
        return ((op >= INST_FADD) && (op <= INST_FDIV)) ||
               (op == INST_SLTF) || (op == INST_BEQF) || (op == INST_BLTF);
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bundle of instruction-memory, execute-facing and writeback signals.
// master = fetch/decode stage, slave = its environment (BRAM + execute).
interface fetch_decode_if #(
    parameter int IMEM_AW = 15
);
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_en;
    logic [31:0]        imem_rdata;
    logic               enable;
    logic [5:0]         opecode;
    logic [4:0]         rd_no;
    logic [4:0]         rs_no;
    logic [4:0]         rt_no;
    logic [15:0]        offset;
    logic [31:0]        pc;
    logic [31:0]        rs;
    logic [31:0]        rt;
    logic               fmode1;
    logic               fmode2;
    logic               stop;
    logic               pcenable;
    logic [31:0]        next_pc;
    logic               wenable;
    logic               wfmode;
    logic [4:0]         wreg;
    logic [31:0]        wdata;

    modport master (
        output imem_addr, imem_en, enable, opecode, rd_no, rs_no, rt_no,
               offset, pc, rs, rt, fmode1, fmode2,
        input  imem_rdata, stop, pcenable, next_pc,
               wenable, wfmode, wreg, wdata
    );

    modport slave (
        input  imem_addr, imem_en, enable, opecode, rd_no, rs_no, rt_no,
               offset, pc, rs, rt, fmode1, fmode2,
        output imem_rdata, stop, pcenable, next_pc,
               wenable, wfmode, wreg, wdata
    );
endinterface

// File: rtl/fetch_decode_regfile_dual.sv
// Integer and float 32x32 register files with two combinational read
// ports, one write port and same-cycle write-to-read bypass.
module regfile_dual (
    input  logic        clk,
    input  logic        i_we,
    input  logic        i_wf,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_ra1,
    input  logic        i_rf1,
    input  logic [4:0]  i_ra2,
    input  logic        i_rf2,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    // NOTE: storage arrays carry no reset; contents are undefined until written.
    logic [31:0] r_int [0:31];
    logic [31:0] r_flt [0:31];

    logic w_hit1;
    logic w_hit2;

    // Write port; integer r0 is hard-wired and never stored
    always_ff @(posedge clk) begin
        if (i_we && !i_wf && (i_waddr != 5'd0)) r_int[i_waddr] <= i_wdata;
        if (i_we && i_wf)                       r_flt[i_waddr] <= i_wdata;
    end

    // A write this cycle matches a read port when file and index agree (not int r0)
    assign w_hit1 = i_we && (i_wf == i_rf1) && (i_waddr == i_ra1) && (i_rf1 || (i_ra1 != 5'd0));
    assign w_hit2 = i_we && (i_wf == i_rf2) && (i_waddr == i_ra2) && (i_rf2 || (i_ra2 != 5'd0));

    // Read port 1: bypass first, then selected file, integer r0 reads zero
    always_comb begin
        if (w_hit1)              o_rd1 = i_wdata;
        else if (i_rf1)          o_rd1 = r_flt[i_ra1];
        else if (i_ra1 == 5'd0)  o_rd1 = 32'd0;
        else                     o_rd1 = r_int[i_ra1];
    end

    // Read port 2: same structure as port 1
    always_comb begin
        if (w_hit2)              o_rd2 = i_wdata;
        else if (i_rf2)          o_rd2 = r_flt[i_ra2];
        else if (i_ra2 == 5'd0)  o_rd2 = 32'd0;
        else                     o_rd2 = r_int[i_ra2];
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: drives a 1-cycle-latency instruction BRAM,
// registers one decoded instruction per cycle toward execute, honours
// stop (hold, with a 1-entry skid) and pcenable/next_pc (redirect).
module fetch_decode
    import inst_set::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IMEM_AW  = 15
) (
    input  logic           clk,
    input  logic           rst,
    fetch_decode_if.master bus
);

    fd_state_t   r_state;
    fd_state_t   w_state_next;
    logic        w_fetch;

    logic [31:0] r_fetch_pc;
    logic        r_inflight;      // BRAM returns a word this cycle
    logic [31:0] r_inflight_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_inst;
    logic [31:0] r_skid_pc;
    logic        r_enable;
    logic [31:0] r_inst;
    logic [31:0] r_pc;

    logic [5:0]  w_opecode;
    logic [4:0]  w_rs_no;
    logic [4:0]  w_rt_no;
    logic        w_fmode1;
    logic        w_fmode2;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so all of them sample pre-edge values.
        if (rst) r_state <= ST_BOOT;
        else     r_state <= w_state_next;
    end

    // Next state and fetch request; redirect overrides everything
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_state_next = r_state;
        w_fetch      = 1'b0;
        case (r_state)
            ST_BOOT:  w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_RUN;
            ST_FLUSH: w_state_next = ST_RUN;
            default:  w_state_next = ST_BOOT;
        endcase
        if ((r_state == ST_RUN || r_state == ST_FLUSH) && !bus.stop && !bus.pcenable)
            w_fetch = 1'b1;
        if (bus.pcenable)
            w_state_next = ST_FLUSH;
    end

    // Fetch PC, in-flight tracking, skid buffer and decode output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
            r_skid_valid  <= 1'b0;
            r_skid_inst   <= 32'd0;
            r_skid_pc     <= 32'd0;
            r_enable      <= 1'b0;
            r_inst        <= 32'd0;
            r_pc          <= 32'd0;
        end else if (bus.pcenable) begin
            // Redirect: drop the returning word and any skid entry
            r_fetch_pc   <= bus.next_pc;
            r_inflight   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_enable     <= 1'b0;
        end else begin
            r_inflight <= w_fetch;
            if (w_fetch) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end
            if (bus.stop) begin
                // Hold outputs; park a returning word (fetch is already off, so one slot suffices)
                if (r_inflight) begin
                    r_skid_inst  <= bus.imem_rdata;
                    r_skid_pc    <= r_inflight_pc;
                    r_skid_valid <= 1'b1;
                end
            end else if (r_skid_valid) begin
                r_inst       <= r_skid_inst;
                r_pc         <= r_skid_pc;
                r_enable     <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_enable <= r_inflight;
                if (r_inflight) begin
                    r_inst <= bus.imem_rdata;
                    r_pc   <= r_inflight_pc;
                end
            end
        end
    end

    assign w_opecode = r_inst[OPC_MSB:OPC_LSB];
    assign w_rs_no   = r_inst[RS_MSB:RS_LSB];
    assign w_rt_no   = r_inst[RT_MSB:RT_LSB];
    assign w_fmode1  = fmode_rs(w_opecode);
    assign w_fmode2  = fmode_rt(w_opecode);

    assign bus.imem_en   = w_fetch;
    assign bus.imem_addr = r_fetch_pc[IMEM_AW+1:2];
    assign bus.enable    = r_enable;
    assign bus.opecode   = w_opecode;
    assign bus.rd_no     = r_inst[RD_MSB:RD_LSB];
    assign bus.rs_no     = w_rs_no;
    assign bus.rt_no     = w_rt_no;
    assign bus.offset    = r_inst[OFF_MSB:OFF_LSB];
    assign bus.pc        = r_pc;
    assign bus.fmode1    = w_fmode1;
    assign bus.fmode2    = w_fmode2;

    // Operands are re-read every cycle so writebacks during a hold show up
    regfile_dual u_regfile (
        .clk     (clk),
        .i_we    (bus.wenable),
        .i_wf    (bus.wfmode),
        .i_waddr (bus.wreg),
        .i_wdata (bus.wdata),
        .i_ra1   (w_rs_no),
        .i_rf1   (w_fmode1),
        .i_ra2   (w_rt_no),
        .i_rf2   (w_fmode2),
        .o_rd1   (bus.rs),
        .o_rd2   (bus.rt)
    );

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: BRAM model, hand-computed expectations.
module tb_fetch_decode;
    import inst_set::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    logic [31:0] mem [0:255];

    fetch_decode_if #(.IMEM_AW(15)) bus ();

    fetch_decode #(.RESET_PC(32'h0), .IMEM_AW(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle-latency instruction BRAM
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr[7:0]];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle at the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  n_cyc;
        logic seen;
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 256; i++) mem[i] = {INST_ADDI, 5'd3, 5'd0, 16'(i)};
        mem[5] = {INST_ADD,  5'd1, 5'd5, 5'd6, 11'd0};
        mem[7] = {INST_FADD, 5'd2, 5'd0, 5'd1, 11'd0};

        rst          = 1'b1;
        bus.stop     = 1'b0;
        bus.pcenable = 1'b0;
        bus.next_pc  = 32'd0;
        bus.wenable  = 1'b0;
        bus.wfmode   = 1'b0;
        bus.wreg     = 5'd0;
        bus.wdata    = 32'd0;
        bus.imem_rdata = 32'd0;

        // Reset state
        step(); step();
        check("rst_enable", 32'(bus.enable), 32'd0);
        check("rst_pc", bus.pc, 32'd0);
        check("rst_opc", 32'(bus.opecode), 32'd0);
        check("rst_imem_en", 32'(bus.imem_en), 32'd0);
        check("rst_rs", bus.rs, 32'd0);
        check("rst_rt", bus.rt, 32'd0);
        rst = 1'b0;
        #1 check("boot_no_fetch", 32'(bus.imem_en), 32'd0);

        // Startup: first fetch one cycle after BOOT, enable on third edge
        step();
        check("run_imem_en", 32'(bus.imem_en), 32'd1);
        check("run_imem_addr", 32'(bus.imem_addr), 32'd0);
        check("c1_enable", 32'(bus.enable), 32'd0);
        step();
        check("c2_enable", 32'(bus.enable), 32'd0);
        step();
        check("c3_enable", 32'(bus.enable), 32'd1);
        check("c3_pc", bus.pc, 32'd0);
        check("c3_opc", 32'(bus.opecode), 32'(INST_ADDI));
        check("c3_rd", 32'(bus.rd_no), 32'd3);
        check("c3_off", 32'(bus.offset), 32'd0);
        step();
        check("c4_pc", bus.pc, 32'd4);
        step();
        check("c5_pc", bus.pc, 32'd8);

        // Hold pc=8 for three cycles; word for pc=12 goes to the skid
        bus.stop = 1'b1;
        #1 check("stop_imem_en", 32'(bus.imem_en), 32'd0);
        step();
        check("hold1_pc", bus.pc, 32'd8);
        check("hold1_en", 32'(bus.enable), 32'd1);
        step();
        check("hold2_pc", bus.pc, 32'd8);
        check("hold2_off", 32'(bus.offset), 32'd2);
        bus.stop = 1'b0;
        #1 check("drain_imem_en", 32'(bus.imem_en), 32'd1);
        check("drain_imem_addr", 32'(bus.imem_addr), 32'd4);
        step();
        check("skid_pc", bus.pc, 32'd12);
        check("skid_off", 32'(bus.offset), 32'd3);
        step();
        check("after_skid_pc", bus.pc, 32'd16);
        check("after_skid_off", 32'(bus.offset), 32'd4);

        // Write to integer r0 is not bypassed
        bus.wenable = 1'b1; bus.wfmode = 1'b0; bus.wreg = 5'd0; bus.wdata = 32'h12345678;
        #1 check("r0_bypass", bus.rs, 32'd0);
        step();
        bus.wenable = 1'b0;
        check("add_pc", bus.pc, 32'd20);
        check("add_opc", 32'(bus.opecode), 32'(INST_ADD));
        check("add_fields", {bus.rd_no, bus.rs_no, bus.rt_no}, {17'd0, 5'd1, 5'd5, 5'd6});
        check("add_fmode1", 32'(bus.fmode1), 32'd0);

        // Bypass of r5 during a hold, then the stored value
        bus.stop = 1'b1;
        bus.wenable = 1'b1; bus.wfmode = 1'b0; bus.wreg = 5'd5; bus.wdata = 32'hDEADBEEF;
        #1 check("r5_bypass", bus.rs, 32'hDEADBEEF);
        step();
        bus.wenable = 1'b0;
        #1 check("r5_stored", bus.rs, 32'hDEADBEEF);
        check("r5_hold_pc", bus.pc, 32'd20);

        // Release hold while writing f0
        bus.stop = 1'b0;
        bus.wenable = 1'b1; bus.wfmode = 1'b1; bus.wreg = 5'd0; bus.wdata = 32'h3F800000;
        step();
        bus.wenable = 1'b0;
        #1 check("pc24", bus.pc, 32'd24);
        check("int_r0_clean", bus.rs, 32'd0);
        step();
        check("fadd_pc", bus.pc, 32'd28);
        check("fadd_opc", 32'(bus.opecode), 32'(INST_FADD));
        check("fadd_fmode1", 32'(bus.fmode1), 32'd1);
        check("fadd_fmode2", 32'(bus.fmode2), 32'd1);
        check("fadd_rs", bus.rs, 32'h3F800000);
        bus.wenable = 1'b1; bus.wfmode = 1'b0; bus.wreg = 5'd0; bus.wdata = 32'hAAAA5555;
        #1 check("f0_mode_mismatch", bus.rs, 32'h3F800000);
        bus.wfmode = 1'b1; bus.wdata = 32'h40000000;
        #1 check("f0_bypass", bus.rs, 32'h40000000);
        bus.wenable = 1'b0;

        // Redirect while stopped
        bus.stop = 1'b1; bus.pcenable = 1'b1; bus.next_pc = 32'h100;
        step();
        bus.stop = 1'b0; bus.pcenable = 1'b0;
        #1 check("flush_en", 32'(bus.enable), 32'd0);
        check("flush_imem_en", 32'(bus.imem_en), 32'd1);
        check("flush_imem_addr", 32'(bus.imem_addr), 32'h40);
        step();
        check("flush2_en", 32'(bus.enable), 32'd0);
        step();
        check("tgt_en", 32'(bus.enable), 32'd1);
        check("tgt_pc", bus.pc, 32'h100);
        check("tgt_off", 32'(bus.offset), 32'h40);
        step();
        check("tgt_next_pc", bus.pc, 32'h104);

        // Redirect again while still in FLUSH: last target wins
        bus.pcenable = 1'b1; bus.next_pc = 32'h200;
        step();
        bus.next_pc = 32'h300;
        #1 check("reflush_en", 32'(bus.enable), 32'd0);
        step();
        bus.pcenable = 1'b0;
        #1 check("reflush_addr", 32'(bus.imem_addr), 32'hC0);
        step();
        check("reflush2_en", 32'(bus.enable), 32'd0);
        step();
        check("retgt_pc", bus.pc, 32'h300);
        check("retgt_off", 32'(bus.offset), 32'hC0);

        // Reset mid-hold with skid full: skid word (pc 0x304) must never issue
        bus.stop = 1'b1;
        step();
        check("pre_rst_pc", bus.pc, 32'h300);
        rst = 1'b1;
        step();
        rst = 1'b0; bus.stop = 1'b0;
        #1 check("mid_rst_en", 32'(bus.enable), 32'd0);
        check("mid_rst_pc", bus.pc, 32'd0);
        check("mid_rst_imem_en", 32'(bus.imem_en), 32'd0);
        n_cyc = 0;
        seen  = 1'b0;
        while (!seen && n_cyc < 10) begin
            step();
            n_cyc++;
            if (bus.enable) seen = 1'b1;
        end
        check("rst_latency", 32'(n_cyc), 32'd3);
        check("rst_first_pc", bus.pc, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
